// File: rtl/mem_unit.sv
// Byte-serial memory stage: splits LB/LH/LW/LBU/LHU/SB/SH/SW into single-byte
// accesses on an 8-bit port. MEM_MISALIGN_CHK_EN enables misaligned-access trapping.

`ifndef RegBus
`define RegBus 32
`endif
`ifndef RegAddrBus
`define RegAddrBus 5
`endif
`ifndef AluOpBus
`define AluOpBus 8
`endif
`ifndef ME_NOP_OP
`define ME_NOP_OP 8'b00000000
`endif
`ifndef EX_LB_OP
`define EX_LB_OP  8'b11100000
`endif
`ifndef EX_LH_OP
`define EX_LH_OP  8'b11100001
`endif
`ifndef EX_LW_OP
`define EX_LW_OP  8'b11100011
`endif
`ifndef EX_LBU_OP
`define EX_LBU_OP 8'b11100100
`endif
`ifndef EX_LHU_OP
`define EX_LHU_OP 8'b11100101
`endif
`ifndef EX_SB_OP
`define EX_SB_OP  8'b11101000
`endif
`ifndef EX_SH_OP
`define EX_SH_OP  8'b11101001
`endif
`ifndef EX_SW_OP
`define EX_SW_OP  8'b11101011
`endif

module mem_unit (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`RegAddrBus-1:0] wd_i,
  input  logic                   wreg_i,
  input  logic [`RegBus-1:0]     wdata_i,
  input  logic [`AluOpBus-1:0]   aluop_i,
  input  logic [`RegBus-1:0]     mem_addr_i,
  output logic [`RegAddrBus-1:0] wd_o,
  output logic                   wreg_o,
  output logic [`RegBus-1:0]     wdata_o,
  output logic                   stall_req_o,
  output logic [31:0]            mem_a_o,
  output logic                   mem_wr_o,
  output logic [7:0]             mem_dout_o,
  input  logic [7:0]             mem_din_i,
  output logic                   misalign_o
);

`ifdef MEM_MISALIGN_CHK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [`RegBus-1:0] asm_q, asm_d;

  logic               is_load, is_store, misaligned, kill;
  logic [2:0]         size;
  logic [`RegBus-1:0] load_val;
  logic [1:0]         cap_idx;
  logic [4:0]         byte_sel, cap_sel;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = 3'd0;
    load_val = asm_q;
    case (aluop_i)
      `EX_LB_OP:  begin is_load = 1'b1; size = 3'd1; load_val = {{24{asm_q[7]}}, asm_q[7:0]}; end
      `EX_LBU_OP: begin is_load = 1'b1; size = 3'd1; load_val = {24'd0, asm_q[7:0]}; end
      `EX_LH_OP:  begin is_load = 1'b1; size = 3'd2; load_val = {{16{asm_q[15]}}, asm_q[15:0]}; end
      `EX_LHU_OP: begin is_load = 1'b1; size = 3'd2; load_val = {16'd0, asm_q[15:0]}; end
      `EX_LW_OP:  begin is_load = 1'b1; size = 3'd4; end
      `EX_SB_OP:  begin is_store = 1'b1; size = 3'd1; end
      `EX_SH_OP:  begin is_store = 1'b1; size = 3'd2; end
      `EX_SW_OP:  begin is_store = 1'b1; size = 3'd4; end
      default: ;
    endcase
  end

  assign misaligned = ((size == 3'd2) && mem_addr_i[0]) ||
                      ((size == 3'd4) && (mem_addr_i[1:0] != 2'b00));
  // Writing r0 is architecturally discarded.
  assign kill     = wreg_i && (wd_i == '0);
  assign cap_idx  = cnt_q[1:0] - 2'd1;
  assign byte_sel = {cnt_q[1:0], 3'b000};
  assign cap_sel  = {cap_idx, 3'b000};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stall_req_o = 1'b0;
    mem_a_o     = '0;
    mem_wr_o    = 1'b0;
    mem_dout_o  = '0;
    misalign_o  = 1'b0;
    if (rst) begin
      state_d = StIdle;
      cnt_d   = 3'd0;
      asm_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if ((is_load || is_store) && ChkEn && misaligned) begin
            wd_o       = wd_i;
            misalign_o = 1'b1;
          end else if (is_load || is_store) begin
            mem_a_o     = mem_addr_i;
            stall_req_o = 1'b1;
            asm_d       = '0;
            cnt_d       = 3'd1;
            if (is_store) begin
              mem_wr_o   = 1'b1;
              mem_dout_o = wdata_i[7:0];
            end
            // A single-byte store has nothing left to transfer.
            state_d = (is_store && size == 3'd1) ? StDone : StXfer;
          end else begin
            wd_o    = wd_i;
            wreg_o  = wreg_i && !kill;
            wdata_o = kill ? '0 : wdata_i;
          end
        end
        StXfer: begin
          stall_req_o = 1'b1;
          cnt_d       = cnt_q + 3'd1;
          if (cnt_q < size) begin
            mem_a_o = mem_addr_i + {29'd0, cnt_q};
            if (is_store) begin
              mem_wr_o   = 1'b1;
              mem_dout_o = wdata_i[byte_sel +: 8];
            end
          end
          if (is_load) begin
            asm_d[cap_sel +: 8] = mem_din_i;
            if (cnt_q == size) state_d = StDone;
          end else if (cnt_q == size - 3'd1) begin
            state_d = StDone;
          end
        end
        StDone: begin
          wd_o    = wd_i;
          cnt_d   = 3'd0;
          state_d = StIdle;
          if (is_load) begin
            wreg_o  = wreg_i && !kill;
            wdata_o = kill ? '0 : load_val;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
    end
  end

endmodule
